// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM:
// state enum, opcodes, datapath mux selects and the control bundle.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_JALR,
    S_JALR2,
    S_BRANCH,
    S_TRAP
  } ctrl_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_J    = 3'b011;
  localparam logic [2:0] IMM_NONE = 3'b111;

  typedef struct packed {
    logic       mem_req;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUop;
    logic [1:0] ResultSrc;
    logic       instr_done;
    logic       trap;
  } ctrl_out_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle between the multicycle FSM and datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       EQ;
  logic       mem_ready;
  logic       mem_req;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUop;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic       instr_done;
  logic       trap;

  modport master (
    input  op, funct3, EQ, mem_ready,
    output mem_req, AdrSrc, IRWrite,
    output PCWrite, MemWrite, RegWrite,
    output ALUSrcA, ALUSrcB, ALUop,
    output ResultSrc, ImmSrc,
    output instr_done, trap
  );

  modport slave (
    output op, funct3, EQ, mem_ready,
    input  mem_req, AdrSrc, IRWrite,
    input  PCWrite, MemWrite, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUop,
    input  ResultSrc, ImmSrc,
    input  instr_done, trap
  );
endinterface

// File: rtl/multicycle_ctrl_immdecode.sv
// Opcode to immediate-format select; independent of FSM state.
module ctrl_immdecode
  import ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  output logic [2:0] o_imm_src
);

  always_comb begin
    o_imm_src = IMM_NONE;
    unique case (i_op)
      OP_LOAD,
      OP_ITYPE,
      OP_JALR:   o_imm_src = IMM_I;
      OP_STORE:  o_imm_src = IMM_S;
      OP_BRANCH: o_imm_src = IMM_B;
      OP_JAL:    o_imm_src = IMM_J;
      default:   o_imm_src = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing the shared multicycle RV32I datapath.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  multicycle_ctrl_if.master bus
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;
  ctrl_out_t   w_out;
  logic        w_take;
  logic        w_rdy;

  assign w_rdy  = bus.mem_ready;
  assign w_take = (bus.funct3 == 3'b000 &&  bus.EQ)
               || (bus.funct3 == 3'b001 && !bus.EQ);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:    if (w_rdy) w_next = S_DECODE;
      S_DECODE: begin
        unique case (bus.op)
          OP_LOAD,
          OP_STORE:  w_next = S_MEMADR;
          OP_RTYPE:  w_next = S_EXECR;
          OP_ITYPE:  w_next = S_EXECI;
          OP_JAL:    w_next = S_JAL;
          OP_JALR:   w_next = S_JALR;
          OP_BRANCH: w_next = S_BRANCH;
          default:   w_next = S_TRAP;
        endcase
      end
      S_MEMADR:
        w_next = (bus.op == OP_LOAD)
               ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (w_rdy) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (w_rdy) w_next = S_FETCH;
      S_EXECR,
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_JALR:     w_next = S_JALR2;
      S_JALR2:    w_next = S_ALUWB;
      S_BRANCH:   w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_out = '0;
    unique case (r_state)
      S_FETCH: begin
        w_out.mem_req   = 1'b1;
        w_out.IRWrite   = w_rdy;
        w_out.PCWrite   = w_rdy;
        w_out.ALUSrcB   = SRCB_FOUR;
        w_out.ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        w_out.ALUSrcA = SRCA_OLDPC;
        w_out.ALUSrcB = SRCB_IMM;
      end
      S_MEMADR, S_JALR: begin
        w_out.ALUSrcA = SRCA_RS1;
        w_out.ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        w_out.mem_req = 1'b1;
        w_out.AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        w_out.ResultSrc  = RES_MEM;
        w_out.RegWrite   = 1'b1;
        w_out.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        w_out.mem_req    = 1'b1;
        w_out.AdrSrc     = 1'b1;
        w_out.MemWrite   = 1'b1;
        w_out.instr_done = w_rdy;
      end
      S_EXECR: begin
        w_out.ALUSrcA = SRCA_RS1;
        w_out.ALUSrcB = SRCB_RS2;
        w_out.ALUop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        w_out.ALUSrcA = SRCA_RS1;
        w_out.ALUSrcB = SRCB_IMM;
        w_out.ALUop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_out.ResultSrc  = RES_ALUOUT;
        w_out.RegWrite   = 1'b1;
        w_out.instr_done = 1'b1;
      end
      // PC takes the target held in ALUOut; ALU forms OldPC+4 for rd
      S_JAL, S_JALR2: begin
        w_out.ALUSrcA   = SRCA_OLDPC;
        w_out.ALUSrcB   = SRCB_FOUR;
        w_out.ResultSrc = RES_ALUOUT;
        w_out.PCWrite   = 1'b1;
      end
      S_BRANCH: begin
        w_out.ALUSrcA    = SRCA_RS1;
        w_out.ALUSrcB    = SRCB_RS2;
        w_out.ALUop      = ALUOP_SUB;
        w_out.ResultSrc  = RES_ALUOUT;
        w_out.PCWrite    = w_take;
        w_out.instr_done = 1'b1;
      end
      S_TRAP:  w_out.trap = 1'b1;
      default: w_out = '0;
    endcase
  end

  // Write strobes are squashed during reset so nothing commits
  assign bus.mem_req    = rst_n & w_out.mem_req;
  assign bus.IRWrite    = rst_n & w_out.IRWrite;
  assign bus.PCWrite    = rst_n & w_out.PCWrite;
  assign bus.MemWrite   = rst_n & w_out.MemWrite;
  assign bus.RegWrite   = rst_n & w_out.RegWrite;
  assign bus.instr_done = rst_n & w_out.instr_done;
  assign bus.AdrSrc     = w_out.AdrSrc;
  assign bus.ALUSrcA    = w_out.ALUSrcA;
  assign bus.ALUSrcB    = w_out.ALUSrcB;
  assign bus.ALUop      = w_out.ALUop;
  assign bus.ResultSrc  = w_out.ResultSrc;
  assign bus.trap       = w_out.trap;

  ctrl_immdecode u_imm (
    .i_op      (bus.op),
    .o_imm_src (bus.ImmSrc)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control
// vectors are queued by the driver and popped by a negedge monitor.
module tb_multicycle_ctrl;

  typedef logic [18:0] vec_t;
  typedef struct {
    vec_t  e;
    string n;
  } item_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  item_t sb[$];

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "timeout");
  end

  function automatic vec_t v(
    bit mr, bit ad, bit ir, bit pc, bit mw, bit rw,
    bit [1:0] sa, bit [1:0] sb_, bit [1:0] ao,
    bit [1:0] rs, bit [2:0] im, bit dn, bit tp);
    return {mr, ad, ir, pc, mw, rw,
            sa, sb_, ao, rs, im, dn, tp};
  endfunction

  function automatic vec_t fF(bit [2:0] im, bit r);
    return v(1,0,r,r,0,0,2'b00,2'b10,2'b00,2'b10,im,0,0);
  endfunction
  function automatic vec_t fD(bit [2:0] im);
    return v(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,im,0,0);
  endfunction
  function automatic vec_t fMA(bit [2:0] im);
    return v(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,im,0,0);
  endfunction
  function automatic vec_t fMR(bit [2:0] im);
    return v(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,im,0,0);
  endfunction
  function automatic vec_t fMWB(bit [2:0] im);
    return v(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,im,1,0);
  endfunction
  function automatic vec_t fMW(bit [2:0] im, bit r);
    return v(1,1,0,0,1,0,2'b00,2'b00,2'b00,2'b00,im,r,0);
  endfunction
  function automatic vec_t fER(bit [2:0] im);
    return v(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,im,0,0);
  endfunction
  function automatic vec_t fEI(bit [2:0] im);
    return v(0,0,0,0,0,0,2'b10,2'b01,2'b10,2'b00,im,0,0);
  endfunction
  function automatic vec_t fWB(bit [2:0] im);
    return v(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,im,1,0);
  endfunction
  function automatic vec_t fJ(bit [2:0] im);
    return v(0,0,0,1,0,0,2'b01,2'b10,2'b00,2'b00,im,0,0);
  endfunction
  function automatic vec_t fBR(bit [2:0] im, bit tk);
    return v(0,0,0,tk,0,0,2'b10,2'b00,2'b01,2'b00,im,1,0);
  endfunction

  function automatic vec_t act();
    return {bus.mem_req, bus.AdrSrc, bus.IRWrite,
            bus.PCWrite, bus.MemWrite, bus.RegWrite,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUop,
            bus.ResultSrc, bus.ImmSrc,
            bus.instr_done, bus.trap};
  endfunction

  task automatic cyc(
    input bit rst, input bit [6:0] o, input bit [2:0] f3,
    input bit eq, input bit rdy, input vec_t e,
    input string nm);
    item_t it;
    rst_n         = rst;
    bus.op        = o;
    bus.funct3    = f3;
    bus.EQ        = eq;
    bus.mem_ready = rdy;
    it.e = e;
    it.n = nm;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    item_t it;
    vec_t  a;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      a  = act();
      checks++;
      if (a !== it.e) begin
        failures++;
        $display("FAIL %s act=%b req=%b", it.n, a, it.e);
      end
    end
  end

  localparam bit [6:0] ADD = 7'b0110011;
  localparam bit [6:0] LW  = 7'b0000011;
  localparam bit [6:0] SW  = 7'b0100011;
  localparam bit [6:0] ADI = 7'b0010011;
  localparam bit [6:0] BR  = 7'b1100011;
  localparam bit [6:0] JL  = 7'b1101111;
  localparam bit [6:0] JR  = 7'b1100111;
  localparam bit [6:0] BAD = 7'b0110111;

  localparam bit [2:0] II = 3'b000;
  localparam bit [2:0] IS = 3'b001;
  localparam bit [2:0] IB = 3'b010;
  localparam bit [2:0] IJ = 3'b011;
  localparam bit [2:0] IN = 3'b111;

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.op        = '0;
    bus.funct3    = '0;
    bus.EQ        = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    cyc(1, ADD, 0, 0, 1, fF(IN, 1), "add.fetch");
    cyc(1, ADD, 0, 0, 1, fD(IN),    "add.decode");
    cyc(1, ADD, 0, 0, 1, fER(IN),   "add.execr");
    cyc(1, ADD, 0, 0, 1, fWB(IN),   "add.aluwb");

    cyc(1, LW, 0, 0, 1, fF(II, 1),  "lw.fetch");
    cyc(1, LW, 0, 0, 0, fD(II),     "lw.decode");
    cyc(1, LW, 0, 0, 0, fMA(II),    "lw.memadr");
    cyc(1, LW, 0, 0, 0, fMR(II),    "lw.wait1");
    cyc(1, LW, 0, 0, 0, fMR(II),    "lw.wait2");
    cyc(1, LW, 0, 0, 1, fMR(II),    "lw.memread");
    cyc(1, LW, 0, 0, 1, fMWB(II),   "lw.memwb");

    cyc(1, BR, 3'b000, 1, 1, fF(IB, 1), "beq.fetch");
    cyc(1, BR, 3'b000, 1, 1, fD(IB),    "beq.decode");
    cyc(1, BR, 3'b000, 1, 1, fBR(IB, 1), "beq.taken");
    cyc(1, BR, 3'b001, 1, 1, fF(IB, 1), "bne.fetch");
    cyc(1, BR, 3'b001, 1, 1, fD(IB),    "bne.decode");
    cyc(1, BR, 3'b001, 1, 1, fBR(IB, 0), "bne.eq.not");
    cyc(1, BR, 3'b001, 0, 1, fF(IB, 1), "bne2.fetch");
    cyc(1, BR, 3'b001, 0, 1, fD(IB),    "bne2.decode");
    cyc(1, BR, 3'b001, 0, 1, fBR(IB, 1), "bne.ne.taken");
    cyc(1, BR, 3'b010, 1, 1, fF(IB, 1), "b010.fetch");
    cyc(1, BR, 3'b010, 1, 1, fD(IB),    "b010.decode");
    cyc(1, BR, 3'b010, 1, 1, fBR(IB, 0), "b010.not");

    cyc(1, JR, 0, 0, 1, fF(II, 1),  "jalr.fetch");
    cyc(1, JR, 0, 0, 1, fD(II),     "jalr.decode");
    cyc(1, JR, 0, 0, 1, fMA(II),    "jalr.jalr");
    cyc(1, JR, 0, 0, 1, fJ(II),     "jalr.jalr2");
    cyc(1, JR, 0, 0, 1, fWB(II),    "jalr.aluwb");

    cyc(1, JL, 0, 0, 1, fF(IJ, 1),  "jal.fetch");
    cyc(1, JL, 0, 0, 1, fD(IJ),     "jal.decode");
    cyc(1, JL, 0, 0, 1, fJ(IJ),     "jal.jal");
    cyc(1, JL, 0, 0, 1, fWB(IJ),    "jal.aluwb");

    cyc(1, ADI, 0, 0, 1, fF(II, 1), "addi.fetch");
    cyc(1, ADI, 0, 0, 1, fD(II),    "addi.decode");
    cyc(1, ADI, 0, 0, 1, fEI(II),   "addi.execi");
    cyc(1, ADI, 0, 0, 1, fWB(II),   "addi.aluwb");

    cyc(1, SW, 0, 0, 0, fF(IS, 0),  "sw.fetchwait");
    cyc(1, SW, 0, 0, 1, fF(IS, 1),  "sw.fetch");
    cyc(1, SW, 0, 0, 1, fD(IS),     "sw.decode");
    cyc(1, SW, 0, 0, 1, fMA(IS),    "sw.memadr");
    cyc(1, SW, 0, 0, 0, fMW(IS, 0), "sw.wait");
    cyc(1, SW, 0, 0, 1, fMW(IS, 1), "sw.memwrite");

    cyc(1, SW, 0, 0, 1, fF(IS, 1),  "swr.fetch");
    cyc(1, SW, 0, 0, 1, fD(IS),     "swr.decode");
    cyc(1, SW, 0, 0, 1, fMA(IS),    "swr.memadr");
    cyc(0, SW, 0, 0, 1,
        v(0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,IS,0,0),
        "swr.rst_gate");
    cyc(1, SW, 0, 0, 0, fF(IS, 0),  "swr.refetch");
    cyc(1, SW, 0, 0, 1, fF(IS, 1),  "swr.fetch2");
    cyc(1, SW, 0, 0, 1, fD(IS),     "swr.decode2");
    cyc(1, SW, 0, 0, 1, fMA(IS),    "swr.memadr2");
    cyc(1, SW, 0, 0, 1, fMW(IS, 1), "swr.memwrite2");

    cyc(1, BAD, 0, 0, 1, fF(IN, 1), "bad.fetch");
    cyc(1, BAD, 0, 0, 1, fD(IN),    "bad.decode");
    for (int i = 0; i < 10; i++)
      cyc(1, BAD, 0, i[0], i[1],
          v(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,IN,0,1),
          $sformatf("trap.hold%0d", i));
    cyc(0, BAD, 0, 0, 1,
        v(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,IN,0,1),
        "trap.rst");
    cyc(1, ADD, 0, 0, 1, fF(IN, 1), "post.fetch");
    cyc(1, ADD, 0, 0, 1, fD(IN),    "post.decode");
    cyc(1, ADD, 0, 0, 1, fER(IN),   "post.execr");
    cyc(1, ADD, 0, 0, 1, fWB(IN),   "post.aluwb");

    for (int i = 0; i < 5 && sb.size() > 0; i++)
      @(posedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain act=%0d req=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM that sequences the shared multicycle RV32I datapath: one ALU, one unified instruction/data memory port, instruction register, register file. Replaces the single-cycle main decoder at core top level. Issues per-state enables and mux selects, waits on a memory ready handshake, and resolves conditional branches from the ALU equality flag.

## Interface
Parameters:
- none; all encodings come from `ctrl_pkg`.

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `op`  in  7  opcode field of the instruction register (IR[6:0])
- `funct3`  in  3  IR[14:12]; 000 = beq, 001 = bne
- `EQ`  in  1  ALU equality flag (rs1 == rs2)
- `mem_ready`  in  1  memory has completed the current access this cycle
- `mem_req`  out  1  memory access request
- `AdrSrc`  out  1  0 = PC, 1 = ALUOut as memory address
- `IRWrite`  out  1  load IR and OldPC
- `PCWrite`  out  1  load PC from Result
- `MemWrite`  out  1  store strobe
- `RegWrite`  out  1  register-file write enable
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1
- `ALUSrcB`  out  2  00 = rs2, 01 = immediate, 10 = constant 4
- `ALUop`  out  2  00 = add, 01 = subtract/compare, 10 = decode funct
- `ResultSrc`  out  2  00 = ALUOut, 01 = memory data, 10 = ALUResult
- `ImmSrc`  out  3  000 I/lw/jalr, 001 S, 010 B, 011 J, 111 none
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction
- `trap`  out  1  illegal opcode seen; held until reset

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, JALR, JALR2, BRANCH, TRAP.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUop=00, ResultSrc=10. IRWrite and PCWrite assert only when mem_ready=1, then go to DECODE. Otherwise hold FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUop=00. This computes the branch/JAL target into ALUOut. Next state depends on op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100111 → JALR
  - 1100011 → BRANCH
  - any other opcode → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUop=00. Goes to MEMREAD if op is lw, otherwise to MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, done. Then FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 while waiting. Holds until mem_ready; done on the mem_ready cycle, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUop=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUop=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, done. Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUop=00, ResultSrc=00, PCWrite=1, then ALUWB. rd receives OldPC+4.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUop=00, then JALR2.
- JALR2: as JAL, then ALUWB.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUop=01, ResultSrc=00, done. Then FETCH.
  - PCWrite = (funct3==000 & EQ) | (funct3==001 & !EQ).
  - Any other funct3: not taken.
- TRAP: trap=1. All enables and mem_req are 0. Stays in TRAP until reset.
- ImmSrc is decoded combinationally from op in every state; unknown opcodes give 111.
- Any select not listed for a state drives 00.

## Timing
- Reset: rst_n low at a rising edge sets state to FETCH and clears trap.
- While rst_n is low, mem_req, IRWrite, PCWrite, MemWrite, RegWrite and instr_done are forced to 0 combinationally.
- Latency with zero memory wait (mem_ready tied high):
  - beq/bne: 3 cycles
  - R-type, I-type, sw, jal: 4 cycles
  - lw, jalr: 5 cycles
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. All outputs stay stable during a wait.
- mem_req stays high until the cycle mem_ready is sampled high. mem_ready outside those three states is ignored.
- Reset asserted mid-instruction abandons it. No partial writes occur after the reset edge.

## Structure
- `ctrl_pkg` holds:
  - state enum `ctrl_state_t`
  - opcode constants `OP_LOAD`, `OP_STORE`, `OP_RTYPE`, `OP_ITYPE`, `OP_JAL`, `OP_JALR`, `OP_BRANCH`
  - encodings for ALUSrcA, ALUSrcB, ResultSrc, ImmSrc and ALUop
- One sub-module, `ctrl_immdecode`: combinational op → ImmSrc.
- FSM state register plus next-state and output logic live in `multicycle_ctrl`.

## Test plan
- add (op=0110011), mem_ready=1 → FETCH, DECODE, EXECR, ALUWB. RegWrite=1 in cycle 4 only; instr_done at cycle 4.
- lw with mem_ready low for 2 cycles in MEMREAD → 7-cycle instruction. mem_req and AdrSrc=1 held; RegWrite only in MEMWB.
- beq with EQ=1 → PCWrite=1 in BRANCH. bne with EQ=1 → PCWrite=0. Both return to FETCH after 3 cycles.
- jalr → JALR then JALR2 with PCWrite=1 and ALUSrcB=10, then ALUWB with RegWrite=1. 5 cycles total.
- op=0110111 (unsupported) → TRAP. trap=1 persists for 10 cycles with all enables 0; rst_n low for 1 cycle → FETCH, trap=0.
- rst_n low during MEMWRITE → MemWrite=0 in the same cycle; FETCH on the next cycle.
